// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the loader, the fetch unit, the arbiter and the memory array.
// slave = arbiter side, master = requesters plus the array that returns mem_rdata.
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          clr_start;
  logic          clr_busy;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_gnt;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic [DW-1:0] f_rdata;
  logic          f_rvalid;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  clr_start, ld_req, ld_addr, ld_data, f_req, f_addr, mem_rdata,
    output clr_busy, ld_gnt, f_gnt, f_rdata, f_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output clr_start, ld_req, ld_addr, ld_data, f_req, f_addr, mem_rdata,
    input  clr_busy, ld_gnt, f_gnt, f_rdata, f_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader writes, fetch reads, sequenced full clear.
// Define MEM_ARB_RR_EN for round-robin on contention; default is loader-first priority.
module mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          ld_win, f_win, ld_pri, contest;
  logic          en, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rvalid;

  assign contest = (state == IDLE) && !bus.clr_start && bus.ld_req && bus.f_req;

`ifdef MEM_ARB_RR_EN
  // 1 = loader won the last contested cycle, 0 = fetch did
  logic last_ld;
  assign ld_pri = !last_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_ld <= 1'b0;
    else if (contest) last_ld <= ld_win;
  end
`else
  assign ld_pri = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      rvalid <= f_win;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_win   = 1'b0;
    f_win    = 1'b0;
    en       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end else if (bus.ld_req && (!bus.f_req || ld_pri)) begin
          ld_win = 1'b1;
          en     = 1'b1;
          we     = 1'b1;
          addr   = bus.ld_addr;
          wdata  = bus.ld_data;
        end else if (bus.f_req) begin
          f_win = 1'b1;
          en    = 1'b1;
          addr  = bus.f_addr;
        end
      end
      CLEAR: begin
        en     = 1'b1;
        we     = 1'b1;
        addr   = cnt;
        cnt_nx = cnt + AW'(1);
        if (cnt == {AW{1'b1}}) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // grants and strobes are gated so nothing reaches the array while reset is low
  assign bus.ld_gnt    = ld_win & rst_n;
  assign bus.f_gnt     = f_win & rst_n;
  assign bus.mem_en    = en & rst_n;
  assign bus.mem_we    = we & rst_n;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.clr_busy  = (state == CLEAR);
  assign bus.f_rvalid  = rvalid;
  assign bus.f_rdata   = rvalid ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port access controller for the 1024 x 16 program/data memory. It shares the memory between the program loader (write stream) and the CPU fetch unit (read port). It also includes a sequenced clear engine that zeroes every word on command. It sits directly between the memory array and its two requesters; nothing else drives the memory pins.

## Interface
Parameters:
- AW, 10, address width (depth = 2**AW words)
- DW, 16, data width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr_start  in  1  single-cycle pulse that starts a full-memory clear
- clr_busy  out  1  high while the clear engine owns the memory
- ld_req  in  1  loader write request
- ld_addr  in  AW  loader write address
- ld_data  in  DW  loader write data
- ld_gnt  out  1  loader write performed this cycle
- f_req  in  1  fetch read request
- f_addr  in  AW  fetch read address
- f_gnt  out  1  fetch read issued this cycle
- f_rdata  out  DW  fetch read data
- f_rvalid  out  1  f_rdata valid this cycle
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, registered by the array, valid the cycle after the read

## Operation
- FSM has two states: IDLE and CLEAR. Reset state is IDLE.
- IDLE, clr_start=1: next state is CLEAR, clear counter <= 0. No grant is issued in this cycle.
- CLEAR: each cycle drives mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=0, then increments the counter.
  - When counter = 2**AW-1, that write completes and the next state is IDLE.
  - Total is exactly 2**AW write cycles.
  - ld_gnt and f_gnt are 0 throughout. clr_start is ignored.
- clr_busy = (state == CLEAR).
- IDLE arbitration is combinational and happens in the same cycle.
  - Only ld_req: ld_gnt=1; mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data.
  - Only f_req: f_gnt=1; mem_en=1, mem_we=0, mem_addr=f_addr, mem_wdata=0.
  - Both: the winner is chosen by the priority rule (see Configuration). The loser sees gnt=0.
  - Neither: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Requester rule: hold req, addr and data stable until gnt is seen high. The transaction completes in the gnt cycle. Dropping req before gnt is legal and abandons the request.
- f_rvalid is a register that captures f_gnt. f_rdata = mem_rdata while f_rvalid=1, else 0.
- Back-to-back fetch grants give one word per cycle.

## Timing
- Write latency: 0 cycles; the write happens in the grant cycle.
- Read latency: f_rvalid and f_rdata arrive 1 cycle after f_gnt.
- Clear: clr_start accepted at edge N. clr_busy is high from N+1 to N+2**AW inclusive. The first grant is possible in cycle N+2**AW+1.
- Reset values (rst_n=0, asynchronous):
  - state=IDLE, counter=0, f_rvalid=0, clr_busy=0, priority flag=0.
  - ld_gnt, f_gnt, mem_en and mem_we are forced 0 while rst_n=0.
- Reset during CLEAR aborts the clear immediately. Words already written stay zero; the rest are untouched.
- A read granted in the cycle before reset asserts loses its f_rvalid.
- clr_start together with ld_req or f_req in IDLE: the clear wins and no grant is issued.

## Configuration
- MEM_ARB_RR_EN defined: round-robin between loader and fetch.
  - A 1-bit flag records the last winner of a contested cycle.
  - On contention, the requester that did not win last time is granted.
  - Uncontested grants do not change the flag. Flag reset value 0 means fetch won last, so the loader wins the first contest.
- MEM_ARB_RR_EN undefined: fixed priority, loader always wins over fetch. No flag register exists.

## Test plan
- Reset, then ld_req addr=0x005 data=0xBEEF and release; then f_req addr=0x005 -> ld_gnt in the request cycle; f_gnt, then f_rvalid=1 with f_rdata=0xBEEF one cycle later.
- Fetch stream addr 0,1,2 with f_req held 3 cycles after preloading 0x0011,0x0022,0x0033 -> f_rvalid high 3 consecutive cycles with data 0x0011,0x0022,0x0033.
- clr_start pulse after loading 0xFFFF everywhere -> clr_busy high exactly 1024 cycles with no grants; subsequent reads of addr 0, 0x200, 0x3FF all return 0x0000.
- ld_req and f_req held together for 4 cycles -> fixed: ld_gnt every cycle, f_gnt never. With MEM_ARB_RR_EN: grants alternate ld, f, ld, f.
- rst_n low at clear counter=100, after loading 0xAAAA everywhere -> clr_busy drops immediately; addr 99 reads 0x0000, addr 100 reads 0xAAAA.
- clr_start asserted with ld_req in IDLE -> ld_gnt=0 that cycle; ld_gnt only after clear completes.
